bz_player_ctrl: RTL and testbench
=================================

// Module: bz_player_ctrl
// PURPOSE
//  Sequencer for the buzzer music ROM (sync-read block RAM, 1-cycle latency, read-enable).
//  Walks note words from a base address and turns each into a square wave on the buzzer pin.
//  Supports start/stop/pause and optional looping.
//  Sits between the CPU-side control register bits and the music ROM / buzzer pad.
// PARAMETERS
//  ADDR_WIDTH   11     ROM address width
//  DATA_WIDTH   12     ROM word width; must be 12 (fixed note-word format below)
//  TONE_DIV     256    clocks per pitch unit; half-period = pitch*TONE_DIV clocks
//  BEAT_CYCLES  50000  clocks per duration unit
//  LOOP         0      1: restart at latched base on end marker or address wrap; 0: stop
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           synchronous reset, active-high
//  start      in   1           level, sampled in IDLE; begin playback at base_addr
//  stop       in   1           abort playback, return to IDLE
//  pause      in   1           level; freeze playback while high
//  base_addr  in   ADDR_WIDTH  first note address, latched on accepted start
//  rom_en     out  1           ROM read enable
//  rom_addr   out  ADDR_WIDTH  ROM address
//  rom_data   in   DATA_WIDTH  ROM read data, valid the cycle after rom_en=1
//  buzzer     out  1           square-wave drive to buzzer
//  busy       out  1           high in any state other than IDLE
//  done       out  1           1-cycle pulse on normal end of song (not on stop)
// BEHAVIOUR
//  Note word: [11:6] pitch (0 = rest, buzzer held 0), [5:0] dur in beats; dur==0 = END marker.
//  Reset: state=IDLE; rom_en=0, rom_addr=0, buzzer=0, busy=0, done=0; all counters 0.
//  FSM: IDLE -> FETCH -> DECODE -> PLAY -> FETCH ...
//   IDLE:   start=1 & stop=0 -> latch base_addr into base and rom_addr; go FETCH.
//   FETCH:  rom_en=1 for exactly 1 cycle at rom_addr; go DECODE.
//   DECODE: rom_data valid; latch pitch/dur. dur==0 -> END handling; else go PLAY.
//   PLAY:   lasts exactly dur*BEAT_CYCLES unpaused cycles, then:
//           rom_addr == 2**ADDR_WIDTH-1 -> END handling (no wrap to 0); else rom_addr+1 -> FETCH.
//   END:    LOOP=1 -> rom_addr=base, go FETCH (no done);
//           LOOP=0 -> done=1 for one cycle, go IDLE.
//  Latency: start sampled at edge k; FETCH in cycle k+1; DECODE in k+2; first PLAY cycle k+3.
//  Tone: on PLAY entry with pitch!=0, buzzer=1.
//   Toggles every pitch*TONE_DIV PLAY cycles; the half-period counter restarts each note.
//   buzzer=0 in IDLE, FETCH, DECODE, during rests and while paused.
//   The 2-cycle FETCH/DECODE gap between notes is intentional.
//  Counters:
//   Half-period counter width = 6+clog2(TONE_DIV).
//   Duration counter width = 6+clog2(BEAT_CYCLES).
//   No overflow is possible by construction.
//  pause=1 in PLAY:
//   Both counters and the phase are frozen; buzzer=0.
//   On release, resume with the saved buzzer phase restored.
//  pause=1 in FETCH/DECODE: no effect; the pause takes hold on PLAY entry.
//  pause in IDLE: ignored.
//  stop=1 in any non-IDLE state:
//   Next cycle state=IDLE, buzzer=0, rom_en=0, no done.
//   stop beats pause and beats a same-cycle END.
//  start while busy is ignored. start & stop together in IDLE: stay IDLE.
//  rst mid-note: all outputs return to reset values on the next edge; the ROM word is discarded.
// TESTING
//  (bench params: TONE_DIV=2, BEAT_CYCLES=8, ADDR_WIDTH=4, ROM model 1-cycle latency)
//  1. ROM[3]=12'h042 (pitch1, dur2), ROM[4]=0; start, base=3:
//     -> rom_en at k+1 addr 3; buzzer=1 at k+3, toggling every 2 clk for 16 clk;
//     -> fetch addr 4; done pulse; then IDLE.
//  2. Rest word 12'h003 -> buzzer stays 0 for 24 cycles; busy=1 throughout.
//  3. pause high for 5 cycles mid-note -> buzzer 0 during the pause;
//     -> PLAY ends exactly 5 cycles later than unpaused; phase continues correctly.
//  4. stop 3 cycles into PLAY -> next cycle busy=0, buzzer=0, done never asserted.
//  5. LOOP=1, ROM[15]=12'h041, base=15:
//     -> after 8 cycles refetch addr 15 (no wrap to 0, no done); repeats until stop.
//  6. rst asserted in DECODE -> next cycle all outputs 0;
//     -> start re-accepted 1 cycle after rst deasserts.

Source files
------------

// File: rtl/bz_player_ctrl.sv
// Buzzer music sequencer: walks 12-bit note words ({pitch[5:0], dur[5:0]}) in a
// sync-read ROM and drives the buzzer with a square wave per note.
module bz_player_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 12,
    parameter int TONE_DIV    = 256,
    parameter int BEAT_CYCLES = 50000,
    parameter int LOOP        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  buzzer,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);
    localparam int HW = 6 + $clog2(TONE_DIV);
    localparam int DW = 6 + $clog2(BEAT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_PLAY   = 2'd3
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic                  rom_en_q;
    logic                  buzzer_q;
    logic                  done_q;
    logic                  phase_q;
    logic [5:0]            pitch_q;
    logic [5:0]            dur_q;
    logic [HW-1:0]         half_cnt_q;
    logic [DW-1:0]         dur_cnt_q;

    logic [5:0]    rd_pitch;
    logic [5:0]    rd_dur;
    logic [HW-1:0] half_last;
    logic [DW-1:0] dur_last;
    logic          note_done;
    logic          song_end;

    // rom_data holds the word addressed in FETCH (rom_en=1) during the DECODE cycle.
    assign rd_pitch  = rom_data[11:6];
    assign rd_dur    = rom_data[5:0];
    assign half_last = HW'(pitch_q) * HW'(TONE_DIV) - HW'(1);
    assign dur_last  = DW'(dur_q) * DW'(BEAT_CYCLES) - DW'(1);
    assign note_done = (state_q == S_PLAY) && !pause && (dur_cnt_q == dur_last);
    // End marker or last note at the top address; stop always takes priority.
    assign song_end  = !stop &&
                       (((state_q == S_DECODE) && (rd_dur == 6'd0)) ||
                        (note_done && (rom_addr_q == {ADDR_WIDTH{1'b1}})));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            buzzer_q   <= 1'b0;
            done_q     <= 1'b0;
            phase_q    <= 1'b0;
            pitch_q    <= '0;
            dur_q      <= '0;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
        end else begin
            rom_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        base_q     <= base_addr;
                        rom_addr_q <= base_addr;
                        rom_en_q   <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= stop ? S_IDLE : S_DECODE;
                end
                S_DECODE: begin
                    pitch_q    <= rd_pitch;
                    dur_q      <= rd_dur;
                    half_cnt_q <= '0;
                    dur_cnt_q  <= '0;
                    phase_q    <= 1'b1;
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else if (rd_dur != 6'd0) begin
                        buzzer_q <= (rd_pitch != 6'd0) && !pause;
                        state_q  <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        buzzer_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (pause) begin
                        buzzer_q <= 1'b0;
                    end else if (note_done) begin
                        buzzer_q <= 1'b0;
                        if (rom_addr_q != {ADDR_WIDTH{1'b1}}) begin
                            rom_addr_q <= rom_addr_q + ADDR_WIDTH'(1);
                            rom_en_q   <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end else begin
                        dur_cnt_q <= dur_cnt_q + DW'(1);
                        // Rests leave the half-period counter parked.
                        if (pitch_q == 6'd0) begin
                            buzzer_q <= 1'b0;
                        end else if (half_cnt_q == half_last) begin
                            half_cnt_q <= '0;
                            phase_q    <= ~phase_q;
                            buzzer_q   <= ~phase_q;
                        end else begin
                            half_cnt_q <= half_cnt_q + HW'(1);
                            buzzer_q   <= phase_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (song_end) begin
                buzzer_q <= 1'b0;
                if (LOOP != 0) begin
                    rom_addr_q <= base_q;
                    rom_en_q   <= 1'b1;
                    state_q    <= S_FETCH;
                end else begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign buzzer    = buzzer_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_bz_player_ctrl.sv
// Bench for bz_player_ctrl: a song-level reference model predicts every output
// cycle for a LOOP=0 and a LOOP=1 instance sharing the same stimulus.
module tb_bz_player_ctrl;
    localparam int AW   = 4;
    localparam int TD   = 2;
    localparam int BEAT = 8;
    localparam int MAXC = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] base_addr = '0;

    logic          rom_en0, rom_en1, buzzer0, buzzer1, busy0, busy1, done0, done1;
    logic [AW-1:0] rom_addr0, rom_addr1;
    logic [1:0]    dbg0, dbg1;
    logic [11:0]   rom_q0 = '0;
    logic [11:0]   rom_q1 = '0;
    logic [11:0]   rom [16];

    // Per-cycle stimulus schedule and model output ({en, addr, buzzer, busy, done}).
    logic          s_rst   [MAXC];
    logic          s_start [MAXC];
    logic          s_stop  [MAXC];
    logic          s_pause [MAXC];
    logic [AW-1:0] s_base  [MAXC];
    logic [7:0]    m_out   [MAXC];
    logic [7:0]    exp_q0[$];
    logic [7:0]    exp_q1[$];

    int            n_vec = 0;
    int            n_bad = 0;
    int            mon_cyc = 0;
    logic          mon_on = 1'b0;
    logic          chk_empty = 1'b0;
    string         scn_name = "";

    int            m_c;
    logic [AW-1:0] m_addr, m_base;
    logic          m_done;

    always #5 clk = ~clk;

    bz_player_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(12), .TONE_DIV(TD), .BEAT_CYCLES(BEAT), .LOOP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .base_addr(base_addr),
        .rom_en(rom_en0), .rom_addr(rom_addr0), .rom_data(rom_q0),
        .buzzer(buzzer0), .busy(busy0), .done(done0), .dbg_state(dbg0)
    );

    bz_player_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(12), .TONE_DIV(TD), .BEAT_CYCLES(BEAT), .LOOP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .base_addr(base_addr),
        .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_q1),
        .buzzer(buzzer1), .busy(busy1), .done(done1), .dbg_state(dbg1)
    );

    // One-cycle-latency ROMs.
    always @(posedge clk) begin
        if (rom_en0) rom_q0 <= rom[rom_addr0];
        if (rom_en1) rom_q1 <= rom[rom_addr1];
    end

    // ---------------- reference model ----------------
    task automatic put(input int c, input logic en, input logic [AW-1:0] a,
                       input logic bz, input logic by, input logic dn);
        if (c < MAXC) m_out[c] = {en, a, bz, by, dn};
    endtask

    task automatic hit_abort(input int c, output bit ab);
        ab = s_rst[c] || s_stop[c];
        if (s_rst[c]) m_addr = '0;
    endtask

    // Plays from m_addr until the song ends or is aborted; m_c left at the next idle cycle.
    task automatic play_song(input bit lp, input int n);
        logic [11:0] word;
        int          pitch, dur, t;
        bit          bz, ab;
        forever begin
            if (m_c >= n) return;
            put(m_c, 1'b1, m_addr, 1'b0, 1'b1, 1'b0);
            hit_abort(m_c, ab);
            m_c++;
            if (ab || m_c >= n) return;
            word = rom[m_addr];
            put(m_c, 1'b0, m_addr, 1'b0, 1'b1, 1'b0);
            hit_abort(m_c, ab);
            if (ab) begin
                m_c++;
                return;
            end
            pitch = int'(word[11:6]);
            dur   = int'(word[5:0]);
            if (dur != 0) begin
                bz = (pitch != 0) && !s_pause[m_c];
                t  = 0;
                m_c++;
                while (t < dur * BEAT) begin
                    if (m_c >= n) return;
                    put(m_c, 1'b0, m_addr, bz, 1'b1, 1'b0);
                    hit_abort(m_c, ab);
                    if (ab) begin
                        m_c++;
                        return;
                    end
                    if (!s_pause[m_c]) t++;
                    if (pitch == 0 || s_pause[m_c]) bz = 1'b0;
                    else bz = ((t / (pitch * TD)) % 2) == 0;
                    m_c++;
                end
                if (m_addr != 4'hF) begin
                    m_addr = m_addr + 4'd1;
                    continue;
                end
            end else begin
                m_c++;
            end
            if (lp) m_addr = m_base;
            else begin
                m_done = 1'b1;
                return;
            end
        end
    endtask

    task automatic model(input bit lp, input int n);
        m_c    = 0;
        m_addr = '0;
        m_base = '0;
        m_done = 1'b0;
        while (m_c < n) begin
            put(m_c, 1'b0, m_addr, 1'b0, 1'b0, m_done);
            m_done = 1'b0;
            if (s_rst[m_c]) begin
                m_addr = '0;
                m_c++;
            end else if (s_start[m_c] && !s_stop[m_c]) begin
                m_base = s_base[m_c];
                m_addr = m_base;
                m_c++;
                play_song(lp, n);
            end else begin
                m_c++;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            s_rst[c]   = 1'b0;
            s_start[c] = 1'b0;
            s_stop[c]  = 1'b0;
            s_pause[c] = 1'b0;
            s_base[c]  = '0;
        end
        for (int i = 0; i < 16; i++) rom[i] = '0;
    endtask

    task automatic run_scn(input string name, input int n);
        model(1'b0, n);
        for (int c = 0; c < n; c++) exp_q0.push_back(m_out[c]);
        model(1'b1, n);
        for (int c = 0; c < n; c++) exp_q1.push_back(m_out[c]);
        scn_name = name;
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; base_addr = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst = s_rst[c]; start = s_start[c]; stop = s_stop[c];
            pause = s_pause[c]; base_addr = s_base[c];
            mon_on = 1'b1;
        end
        @(posedge clk);
        #1;
        mon_on = 1'b0; chk_empty = 1'b1;
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        @(posedge clk);
        #1;
        chk_empty = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp_one(input string tag, input logic [7:0] got, input logic [7:0] exp,
                           input logic [1:0] st);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s %s cyc %0d: got en/addr/bz/busy/done=%b required %b (state %0d)",
                     scn_name, tag, mon_cyc, got, exp, st);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q0.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL %s loop0 cyc %0d: got %b, required entry missing", scn_name, mon_cyc,
                         {rom_en0, rom_addr0, buzzer0, busy0, done0});
            end else begin
                cmp_one("loop0", {rom_en0, rom_addr0, buzzer0, busy0, done0}, exp_q0.pop_front(), dbg0);
            end
            if (exp_q1.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL %s loop1 cyc %0d: got %b, required entry missing", scn_name, mon_cyc,
                         {rom_en1, rom_addr1, buzzer1, busy1, done1});
            end else begin
                cmp_one("loop1", {rom_en1, rom_addr1, buzzer1, busy1, done1}, exp_q1.pop_front(), dbg1);
            end
            mon_cyc <= mon_cyc + 1;
        end else begin
            mon_cyc <= 0;
        end
        if (chk_empty) begin
            n_vec++;
            if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
                n_bad++;
                $display("FAIL %s drain: got %0d/%0d leftover entries required 0/0",
                         scn_name, exp_q0.size(), exp_q1.size());
                exp_q0.delete();
                exp_q1.delete();
            end
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        bit p;
        int d;
        clear_sched();

        clear_sched();
        rom[3] = 12'h042;
        s_start[2] = 1'b1; s_base[2] = 4'd3;
        run_scn("note", 40);

        clear_sched();
        rom[0] = 12'h003;
        s_start[1] = 1'b1; s_stop[1] = 1'b1;
        s_start[2] = 1'b1; s_base[2] = 4'd0;
        run_scn("rest", 45);

        clear_sched();
        rom[3] = 12'h042;
        s_start[1] = 1'b1; s_base[1] = 4'd3;
        for (int c = 8; c <= 12; c++) s_pause[c] = 1'b1;
        run_scn("pause", 45);

        clear_sched();
        rom[3] = 12'h042;
        s_start[1] = 1'b1; s_base[1] = 4'd3;
        s_stop[6] = 1'b1; s_pause[6] = 1'b1;
        run_scn("stop", 20);

        clear_sched();
        rom[15] = 12'h041;
        s_start[1] = 1'b1; s_base[1] = 4'd15;
        s_stop[60] = 1'b1;
        run_scn("top", 70);

        clear_sched();
        rom[3] = 12'h042;
        s_start[1] = 1'b1; s_base[1] = 4'd3;
        s_rst[3] = 1'b1; s_start[3] = 1'b1; s_base[3] = 4'd3;
        s_start[4] = 1'b1; s_base[4] = 4'd3;
        run_scn("rst", 40);

        for (int r = 0; r < 10; r++) begin
            clear_sched();
            for (int i = 0; i < 16; i++) begin
                d = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 3));
                rom[i] = {6'($urandom_range(0, 3)), 6'(d)};
            end
            p = 1'b0;
            for (int c = 0; c < 240; c++) begin
                if ($urandom_range(0, 9) == 0) p = !p;
                s_pause[c] = p;
                s_rst[c]   = ($urandom_range(0, 149) == 0);
                s_start[c] = ($urandom_range(0, 3) == 0);
                s_stop[c]  = ($urandom_range(0, 69) == 0);
                s_base[c]  = 4'($urandom_range(0, 15));
            end
            run_scn("rand", 240);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
